// File: rtl/fixpoint_pkg.sv
// Shared constants and helpers for the fixed-point format converters.
package fixpoint_pkg;

   // Width of the saturation event counter.
   localparam int unsigned SM2TC_CNT_W = 16;

   // Entries in the sign-magnitude to two's-complement output buffer.
   localparam int unsigned FIFO_DEPTH = 2;

   // Bit index of the sign in a sign-magnitude word with w magnitude bits.
   function automatic int unsigned sign_idx(input int unsigned w);
      return w;
   endfunction

endpackage

// File: rtl/fixpoint_sm2tc_conv.sv
// Combinational sign-magnitude to two's-complement converter.
// With FIXPOINT_SM2TC_SAT_EN defined, overflowed words clamp to the nearest
// representable value; otherwise they keep the low Width bits (wrap).
module fixpoint_sm2tc_conv
   import fixpoint_pkg::*;
#(
   parameter int unsigned Width = 15
) (
   input  logic [Width:0]   sm_i,
   output logic [Width-1:0] tc_o,
   output logic             ovf_o
);

   localparam int unsigned   SignIdx = sign_idx(Width);
   // Most negative code, also the largest magnitude that fits when negative.
   localparam logic [Width-1:0] MinNeg = {1'b1, {(Width-1){1'b0}}};
   localparam logic [Width-1:0] MaxPos = ~MinNeg;
   localparam logic [Width-1:0] One    = {{(Width-1){1'b0}}, 1'b1};

   logic             sign;
   logic [Width-1:0] mag;
   logic [Width-1:0] neg;
   logic [Width-1:0] wrapped;

   // Convert and flag words that fall outside the two's-complement range.
   always_comb begin
      sign    = sm_i[SignIdx];
      mag     = sm_i[Width-1:0];
      neg     = ~mag + One;
      wrapped = sign ? neg : mag;
      if (sign) begin
         ovf_o = (mag > MinNeg);
      end else begin
         ovf_o = mag[Width-1];
      end
`ifdef FIXPOINT_SM2TC_SAT_EN
      if (ovf_o) begin
         tc_o = sign ? MinNeg : MaxPos;
      end else begin
         tc_o = wrapped;
      end
`else
      tc_o = wrapped;
`endif
   end

endmodule

// File: rtl/fix_point_sm2tc.sv
// Streaming sign-magnitude to two's-complement converter with a 2-entry
// output buffer. Words are converted on entry so every output is registered.
// Optional feature macro: FIXPOINT_SM2TC_SAT_EN (clamp on overflow, sat_cnt).
module fix_point_sm2tc
   import fixpoint_pkg::*;
#(
   parameter int unsigned Width = 15
) (
   input  logic                   clk,
   input  logic                   RSTn,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [Width:0]         in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [Width-1:0]       out_data,
`ifdef FIXPOINT_SM2TC_SAT_EN
   output logic [SM2TC_CNT_W-1:0] sat_cnt,
`endif
   output logic                   out_ovf
);

   logic [Width-1:0] data_q [FIFO_DEPTH];
   logic [Width-1:0] data_d [FIFO_DEPTH];
   logic             ovf_q  [FIFO_DEPTH];
   logic             ovf_d  [FIFO_DEPTH];
   logic [1:0]       count_q, count_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [Width-1:0] conv_data;
   logic             conv_ovf;
   logic             push;
   logic             pop;

   fixpoint_sm2tc_conv #(
      .Width (Width)
   ) u_conv (
      .sm_i  (in_data),
      .tc_o  (conv_data),
      .ovf_o (conv_ovf)
   );

   // Handshake outputs depend only on the registered count.
   always_comb begin
      in_ready  = (count_q != 2'd2);
      out_valid = (count_q != 2'd0);
      out_data  = data_q[rd_ptr_q];
      out_ovf   = ovf_q[rd_ptr_q];
      push      = in_valid & in_ready;
      pop       = out_valid & out_ready;
   end

   // Buffer next state: write converted word at push, advance pointers.
   always_comb begin
      data_d   = data_q;
      ovf_d    = ovf_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         data_d[wr_ptr_q] = conv_data;
         ovf_d[wr_ptr_q]  = conv_ovf;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Buffer state register; reset discards any buffered words.
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         data_q   <= '{default: '0};
         ovf_q    <= '{default: 1'b0};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         data_q   <= data_d;
         ovf_q    <= ovf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

`ifdef FIXPOINT_SM2TC_SAT_EN
   logic [SM2TC_CNT_W-1:0] sat_cnt_q, sat_cnt_d;

   // Count pushes of overflowed words, sticking at all-ones.
   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (push && conv_ovf && (sat_cnt_q != {SM2TC_CNT_W{1'b1}})) begin
         sat_cnt_d = sat_cnt_q + {{(SM2TC_CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Saturation counter register.
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         sat_cnt_q <= '0;
      end else begin
         sat_cnt_q <= sat_cnt_d;
      end
   end

   assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_fix_point_sm2tc.sv
// Self-checking bench for fix_point_sm2tc (Width=15). Honors
// FIXPOINT_SM2TC_SAT_EN the same way as the design.
module tb_fix_point_sm2tc;

   localparam int W = 15;

   logic          clk;
   logic          RSTn;
   logic          in_valid;
   logic          in_ready;
   logic [W:0]    in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic          out_ovf;
`ifdef FIXPOINT_SM2TC_SAT_EN
   logic [15:0]   sat_cnt;
`endif

   fix_point_sm2tc #(
      .Width (W)
   ) dut (
      .clk       (clk),
      .RSTn      (RSTn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
`ifdef FIXPOINT_SM2TC_SAT_EN
      .sat_cnt   (sat_cnt),
`endif
      .out_ovf   (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] d;
      logic         o;
   } ent_t;

   typedef struct {
      logic [W:0]   din;
      logic [W-1:0] exp_d;
      logic         exp_o;
   } vec_t;

   int   errors = 0;
   int   checks = 0;
   ent_t q[$];
   int   sat_exp = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference conversion from the numeric value of the sign-magnitude word.
   function automatic ent_t model(input logic [W:0] w);
      ent_t        e;
      int          m;
      int          v;
      logic [31:0] t;
      m   = int'(w[W-1:0]);
      v   = w[W] ? -m : m;
      e.o = (v > 16383) || (v < -16384);
      t   = v;
      e.d = t[W-1:0];
`ifdef FIXPOINT_SM2TC_SAT_EN
      if (e.o) e.d = (v > 0) ? 15'h3FFF : 15'h4000;
`endif
      return e;
   endfunction

   // One cycle starting at a negedge: drive, check against the queue model,
   // then advance the model across the coming rising edge.
   task automatic step(input logic iv, input logic [W:0] id, input logic ordy);
      ent_t e;
      logic do_push;
      logic do_pop;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      #1;
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (q.size() != 0) begin
         chk("out_data", 32'(out_data), 32'(q[0].d));
         chk("out_ovf", 32'(out_ovf), 32'(q[0].o));
      end
`ifdef FIXPOINT_SM2TC_SAT_EN
      chk("sat_cnt", 32'(sat_cnt), 32'(sat_exp));
`endif
      do_push = iv && (q.size() < 2);
      do_pop  = ordy && (q.size() > 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
         e = model(id);
         q.push_back(e);
         if (e.o && sat_exp < 65535) sat_exp++;
      end
      @(negedge clk);
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{16'h0005, 15'h0005, 1'b0};
      vecs[1] = '{16'h8005, 15'h7FFB, 1'b0};
      vecs[2] = '{16'h8000, 15'h0000, 1'b0};
      vecs[3] = '{16'hC000, 15'h4000, 1'b0};
`ifdef FIXPOINT_SM2TC_SAT_EN
      vecs[4] = '{16'h4000, 15'h3FFF, 1'b1};
      vecs[5] = '{16'hC001, 15'h4000, 1'b1};
`else
      vecs[4] = '{16'h4000, 15'h4000, 1'b1};
      vecs[5] = '{16'hC001, 15'h3FFF, 1'b1};
`endif

      RSTn      = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #3;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      RSTn = 1'b1;
      #1;
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_ovf", 32'(out_ovf), 32'd0);
`ifdef FIXPOINT_SM2TC_SAT_EN
      chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
`endif
      @(negedge clk);

      // Reset mid-stream with two words buffered.
      step(1'b1, 16'h0011, 1'b0);
      step(1'b1, 16'h8022, 1'b0);
      in_valid = 1'b0;
      #1;
      chk("full_in_ready", 32'(in_ready), 32'd0);
      #1;
      RSTn = 1'b0;
      #1;
      chk("async_rst_out_valid", 32'(out_valid), 32'd0);
      chk("async_rst_in_ready", 32'(in_ready), 32'd1);
      q.delete();
      sat_exp = 0;
      @(negedge clk);
      RSTn = 1'b1;
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);

      // Conversion table: each word visible the cycle after its accept.
      for (int i = 0; i < 6; i++) begin
         in_valid  = 1'b1;
         in_data   = vecs[i].din;
         out_ready = 1'b1;
         @(negedge clk);
         chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].exp_d));
         chk($sformatf("vec%0d_out_ovf", i), 32'(out_ovf), 32'(vecs[i].exp_o));
         chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
         if (vecs[i].exp_o) sat_exp++;
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("tbl_drain_out_valid", 32'(out_valid), 32'd0);
`ifdef FIXPOINT_SM2TC_SAT_EN
      chk("tbl_sat_cnt", 32'(sat_cnt), 32'd2);
`endif

      // Backpressure: A, B fill the buffer, C stalls until space opens.
      step(1'b1, 16'h0123, 1'b0);
      step(1'b1, 16'h8456, 1'b0);
      step(1'b1, 16'h0789, 1'b0);
      step(1'b1, 16'h0789, 1'b1);
      step(1'b1, 16'h0789, 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      chk("bp_drained", 32'(q.size()), 32'd0);

      // Streaming random words with edge values mixed in.
      for (int i = 0; i < 100; i++) begin
         logic [W:0] w;
         case ($urandom_range(0, 5))
            0:       w = 16'h4000;
            1:       w = 16'hC000;
            2:       w = 16'hC001;
            3:       w = {1'b1, 15'h0000};
            default: w = 16'($urandom);
         endcase
         step(1'b1, w, 1'b1);
      end
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
